// File: rtl/mod_correct_serial_if.sv
// Request/response bundle for the modular correction stage.
// The producer side (the upstream adder or a testbench) uses the master modport;
// the correction stage uses the slave modport.
interface mod_correct_serial_if #(
    parameter int N = 4096
);
    logic [N+2:0] din;      // raw two's-complement sum/difference
    logic         din_neg;  // 1 = din is negative
    logic         mode;     // 1 = came from addition, 0 = from subtraction
    logic [N-1:0] mod_m;    // modulus M
    logic         vld_in;   // request, sampled only while in_rdy=1
    logic         in_rdy;   // high while the stage can accept a request
    logic [N-1:0] dout;     // reduced result in [0, M)
    logic         vld_out;  // one-cycle pulse when dout is updated
    logic         busy;     // high from acceptance through the vld_out cycle

    modport master (
        output din, din_neg, mode, mod_m, vld_in,
        input  in_rdy, dout, vld_out, busy
    );

    modport slave (
        input  din, din_neg, mode, mod_m, vld_in,
        output in_rdy, dout, vld_out, busy
    );
endinterface

// File: rtl/mod_correct_serial.sv
// Block-serial modular correction: folds the raw add/sub result back into [0, M).
// One Block-wide add/sub slice is reused over MAX cycles, matching the upstream
// adder's slicing so both stages close timing at the same clock.
// Operand r and modulus m are rotated right by one slice per cycle, so the active
// slice always sits in the low bits; after MAX rotations both are back in place.
// The result t fills in from the MSB end. One extra RUN step then picks between
// r and t and registers dout, and the DONE cycle carries the vld_out pulse.
module mod_correct_serial #(
    parameter int N     = 4096,
    parameter int Block = 128,
    parameter int MAX   = N / Block
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mod_correct_serial_if.slave  bus
);
    localparam int            KW     = $clog2(MAX + 1);
    localparam logic [KW-1:0] K_LAST = KW'(MAX);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [KW-1:0]  k;          // slice counter; k == MAX is the resolve step
    logic           cy;         // carry (add) or borrow (sub) between slices
    logic           neg;
    logic           md;
    logic [N+2:0]   r;          // latched raw input; low N bits rotate
    logic [N-1:0]   m;          // latched modulus; rotates with r
    logic [N-1:0]   t;          // r +/- M built up slice by slice

    logic [Block-1:0] r_slice;
    logic [Block-1:0] m_slice;
    logic [Block:0]   slice_sum;
    logic [N-1:0]     r_rot;
    logic [N-1:0]     m_rot;
    logic [N-1:0]     t_shift;
    logic [2:0]       hi;
    logic [N-1:0]     result;

    // Slice arithmetic on the low Block bits plus the final r-vs-t selection
    always_comb begin
        r_slice   = r[Block-1:0];
        m_slice   = m[Block-1:0];
        // NOTE: every variable gets a default here, so no path leaves it unassigned and no latch is inferred.
        slice_sum = {1'b0, r_slice};
        if (md) begin
            slice_sum = {1'b0, r_slice} - {1'b0, m_slice} - {{Block{1'b0}}, cy};
        end else if (neg) begin
            slice_sum = {1'b0, r_slice} + {1'b0, m_slice} + {{Block{1'b0}}, cy};
        end

        // hi >= 0 in add mode means r >= M, so the subtracted value is kept
        hi     = r[N+2:N] - {2'b0, cy};
        result = r[N-1:0];
        if (md) begin
            if ($signed(hi) >= 3'sd0) begin
                result = t;
            end
        end else if (neg) begin
            result = t;
        end
    end

    // Slice rotation / result shift; a single slice degenerates to pass-through
    if (MAX > 1) begin : g_multi
        assign r_rot   = {r[Block-1:0], r[N-1:Block]};
        assign m_rot   = {m[Block-1:0], m[N-1:Block]};
        assign t_shift = {slice_sum[Block-1:0], t[N-1:Block]};
    end else begin : g_single
        assign r_rot   = r[N-1:0];
        assign m_rot   = m;
        assign t_shift = slice_sum[Block-1:0];
    end

    // Control FSM with registered outputs; datapath registers advance in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset too, so an aborted operation leaves nothing behind.
        if (!rst_n) begin
            state       <= IDLE;
            k           <= '0;
            cy          <= 1'b0;
            neg         <= 1'b0;
            md          <= 1'b0;
            r           <= '0;
            m           <= '0;
            t           <= '0;
            bus.dout    <= '0;
            bus.vld_out <= 1'b0;
            bus.busy    <= 1'b0;
            bus.in_rdy  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            case (state)
                IDLE: begin
                    if (bus.vld_in && bus.in_rdy) begin
                        r          <= bus.din;
                        neg        <= bus.din_neg;
                        md         <= bus.mode;
                        m          <= bus.mod_m;
                        k          <= '0;
                        cy         <= 1'b0;
                        bus.busy   <= 1'b1;
                        bus.in_rdy <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (k == K_LAST) begin
                        bus.dout    <= result;
                        bus.vld_out <= 1'b1;
                        state       <= DONE;
                    end else begin
                        r[N-1:0] <= r_rot;
                        m        <= m_rot;
                        t        <= t_shift;
                        cy       <= slice_sum[Block];
                        k        <= k + 1'b1;
                    end
                end
                DONE: begin
                    bus.vld_out <= 1'b0;
                    bus.busy    <= 1'b0;
                    bus.in_rdy  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_correct_serial.sv
// Directed and randomized bench for mod_correct_serial (N=256, Block=64).
// Expected results come from spec-given constants or a whole-number model that
// reduces the raw input with plain wide arithmetic.
module tb_mod_correct_serial;
    localparam int N   = 256;
    localparam int BLK = 64;
    localparam int MAX = N / BLK;
    localparam int W   = N + 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    mod_correct_serial_if #(.N(N)) bus ();

    mod_correct_serial #(.N(N), .Block(BLK), .MAX(MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-number reduction of the raw input into [0, M)
    function automatic logic [N-1:0] model(input logic [W-1:0] d, input logic neg,
                                           input logic mode, input logic [N-1:0] m);
        logic [W-1:0] mw;
        logic [W-1:0] s;
        mw = {3'b000, m};
        if (mode)     s = (d >= mw) ? d - mw : d;
        else if (neg) s = d + mw;
        else          s = d;
        return s[N-1:0];
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        v = '0;
        for (int w = 0; w < 9; w++) v = (v << 32) | W'($urandom);
        return v;
    endfunction

    task automatic drive(input logic [W-1:0] d, input logic neg, input logic mode,
                         input logic [N-1:0] m);
        bus.din     = d;
        bus.din_neg = neg;
        bus.mode    = mode;
        bus.mod_m   = m;
    endtask

    // One complete operation: latency, busy span, result and return to idle
    task automatic do_op(input string tag, input logic [W-1:0] d, input logic neg,
                         input logic mode, input logic [N-1:0] m, input logic [N-1:0] exp);
        int lat;
        int bc;
        @(negedge clk);
        drive(d, neg, mode, m);
        bus.vld_in = 1'b1;
        @(negedge clk);
        bus.vld_in = 1'b0;
        lat = 0;
        bc  = 0;
        while (bus.vld_out !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
        if (bus.busy === 1'b1) bc++;
        check({tag, ":latency"}, W'(lat), W'(MAX + 1));
        check({tag, ":dout"}, W'(bus.dout), W'(exp));
        @(negedge clk);
        check({tag, ":vld_out_pulse"}, W'(bus.vld_out), W'(0));
        check({tag, ":in_rdy_back"}, W'(bus.in_rdy), W'(1));
        check({tag, ":busy_cycles"}, W'(bc), W'(MAX + 2));
    endtask

    initial begin
        logic [N-1:0] m0;
        logic [N-1:0] mall;
        logic [W-1:0] mw;
        logic [W-1:0] d;
        logic [N-1:0] seen;
        int           pulses;
        int           lat;

        bus.vld_in = 1'b0;
        drive('0, 1'b0, 1'b0, '0);
        m0   = (N'(1) << 255) + N'(19);
        mw   = {3'b000, m0};
        mall = '1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst:dout", W'(bus.dout), W'(0));
        check("rst:vld_out", W'(bus.vld_out), W'(0));
        check("rst:busy", W'(bus.busy), W'(0));
        check("rst:in_rdy", W'(bus.in_rdy), W'(1));
        rst_n = 1'b1;

        // Add mode and its boundaries
        do_op("add_m_plus_5", mw + W'(5), 1'b0, 1'b1, m0, N'(5));
        do_op("add_eq_m", mw, 1'b0, 1'b1, m0, N'(0));
        do_op("add_m_minus_1", mw - W'(1), 1'b0, 1'b1, m0, m0 - N'(1));
        do_op("add_2m_minus_1", (mw << 1) - W'(1), 1'b0, 1'b1, m0, m0 - N'(1));

        // Sub mode
        do_op("sub_neg3", W'(0) - W'(3), 1'b1, 1'b0, m0, m0 - N'(3));
        do_op("sub_neg_m", W'(0) - mw, 1'b1, 1'b0, m0, N'(0));
        do_op("sub_pos7", W'(7), 1'b0, 1'b0, m0, N'(7));
        do_op("sub_zero", W'(0), 1'b0, 1'b0, m0, N'(0));
        do_op("sub_carry_chain", '1, 1'b1, 1'b0, mall, mall - N'(1));

        // Second pulse two cycles after acceptance must be dropped
        @(negedge clk);
        drive(mw + W'(9), 1'b0, 1'b1, m0);
        bus.vld_in = 1'b1;
        @(negedge clk);
        bus.vld_in = 1'b0;
        @(negedge clk);
        drive(W'(123), 1'b0, 1'b0, m0);
        bus.vld_in = 1'b1;
        @(negedge clk);
        bus.vld_in = 1'b0;
        pulses = 0;
        seen   = '0;
        repeat (14) begin
            if (bus.vld_out === 1'b1) begin
                pulses++;
                seen = bus.dout;
            end
            @(negedge clk);
        end
        check("b2b:pulses", W'(pulses), W'(1));
        check("b2b:dout", W'(seen), W'(9));
        check("b2b:idle_busy", W'(bus.busy), W'(0));

        // vld_in held through DONE: second op accepted the cycle after vld_out
        @(negedge clk);
        drive(W'(0) - W'(5), 1'b1, 1'b0, m0);
        bus.vld_in = 1'b1;
        lat = 0;
        while (bus.vld_out !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("hold:first_latency", W'(lat), W'(MAX + 2));
        check("hold:first_dout", W'(bus.dout), W'(m0 - N'(5)));
        drive(mw + W'(100), 1'b0, 1'b1, m0);
        @(negedge clk);
        check("hold:in_rdy_after_done", W'(bus.in_rdy), W'(1));
        check("hold:not_yet_busy", W'(bus.busy), W'(0));
        @(negedge clk);
        check("hold:second_accepted", W'(bus.busy), W'(1));
        bus.vld_in = 1'b0;
        lat = 0;
        while (bus.vld_out !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("hold:second_latency", W'(lat), W'(MAX + 1));
        check("hold:second_dout", W'(bus.dout), W'(100));
        @(negedge clk);

        // Reset during RUN slice 2 aborts the operation
        @(negedge clk);
        drive(W'(0) - W'(1), 1'b1, 1'b0, m0);
        bus.vld_in = 1'b1;
        @(negedge clk);
        bus.vld_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_run:busy_before", W'(bus.busy), W'(1));
        rst_n = 1'b0;
        #1;
        check("rst_run:dout", W'(bus.dout), W'(0));
        check("rst_run:busy", W'(bus.busy), W'(0));
        check("rst_run:in_rdy", W'(bus.in_rdy), W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            if (bus.vld_out === 1'b1) pulses++;
            @(negedge clk);
        end
        check("rst_run:no_vld_out", W'(pulses), W'(0));
        do_op("post_reset", W'(0) - W'(3), 1'b1, 1'b0, m0, m0 - N'(3));

        // Randomized operations against the whole-number model
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] rw;
            logic [W-1:0] tw;
            logic [W-1:0] x;
            logic [W-1:0] mr;
            logic [N-1:0] rm;
            rw = rand_wide();
            rm = rw[N-1:0];
            if (i % 6 == 5) rm = mall;
            if (rm == '0) rm = N'(1);
            mr = {3'b000, rm};
            tw = mr << 1;
            rw = rand_wide();
            x  = rw % tw;
            if ($urandom_range(1, 0) == 1) begin
                do_op($sformatf("rand%0d_add", i), x, 1'b0, 1'b1, rm, model(x, 1'b0, 1'b1, rm));
            end else begin
                d = x - mr;
                do_op($sformatf("rand%0d_sub", i), d, d[W-1], 1'b0, rm, model(d, d[W-1], 1'b0, rm));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
